// File: rtl/char_sweep_pkg.sv
// rtl/char_sweep_pkg.sv - shared types and default grid sizes for the characterization sweep sequencer
package char_sweep_pkg;

  localparam int DEF_NBSLOPES       = 7;
  localparam int DEF_NBCAPA         = 7;
  localparam int DEF_TICK_CYCLES    = 10;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [3:0] {
    IDLE,
    SET_SLOPE,
    SET_CAPA,
    ARM,
    EDGE,
    MEASURE,
    RESTORE,
    DONE,
    ERROR
  } sweep_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } sweep_err_e;

  // States whose duration is one quiet interval of the tick timer
  function automatic logic is_tick_state(sweep_state_e s);
    return (s == SET_SLOPE) || (s == SET_CAPA) || (s == ARM) ||
           (s == EDGE) || (s == RESTORE);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - loadable down-counter that saturates at zero and flags expiry
module tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Loading N-1 makes the owning state last exactly N cycles
  assign expired = (count == '0);

endmodule

// File: rtl/char_sweep_sequencer.sv
// rtl/char_sweep_sequencer.sv - slope x capacitance sweep sequencer; CHAR_SWEEP_TIMEOUT_EN adds an ack watchdog
module char_sweep_sequencer
  import char_sweep_pkg::*;
#(
  parameter  int NBSLOPES       = DEF_NBSLOPES,
  parameter  int NBCAPA         = DEF_NBCAPA,
  parameter  int TICK_CYCLES    = DEF_TICK_CYCLES,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int SW             = (NBSLOPES > 1) ? $clog2(NBSLOPES) : 1,
  localparam int CW             = (NBCAPA > 1) ? $clog2(NBCAPA) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dout,
  input  logic          meas_ack,
  output logic          din,
  output logic [SW-1:0] slope_idx,
  output logic [CW-1:0] capa_idx,
  output logic          meas_req,
  output logic          row_end,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);

  localparam int            TW         = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LOAD  = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SLOPE_LAST = SW'(NBSLOPES - 1);
  localparam logic [CW-1:0] CAPA_LAST  = CW'(NBCAPA - 1);

  if (TICK_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("char_sweep_sequencer: TICK_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  sweep_state_e state;
  logic         start_ok;
  logic         handshake;
  logic         tick_load;
  logic         tick_expired;
  logic         wd_expired;

  assign start_ok  = ((state == IDLE) || (state == DONE)) && start;
  assign handshake = (state == MEASURE) && meas_ack;
  // Reload on every exit from a timed state, from a start and from a handshake
  assign tick_load = start_ok || (is_tick_state(state) && tick_expired) || handshake;

  tick_timer #(.WIDTH(TW)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tick_load),
    .load_value (TICK_LOAD),
    .expired    (tick_expired)
  );

`ifdef CHAR_SWEEP_TIMEOUT_EN
  localparam int            WW      = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);

  logic wd_load;
  assign wd_load = (state == EDGE) && tick_expired;

  tick_timer #(.WIDTH(WW)) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (wd_load),
    .load_value (WD_LOAD),
    .expired    (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      din       <= 1'b1;
      slope_idx <= '0;
      capa_idx  <= '0;
      meas_req  <= 1'b0;
      row_end   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      row_end <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SET_SLOPE;
            slope_idx <= '0;
            capa_idx  <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SET_SLOPE: if (tick_expired) state <= SET_CAPA;
        SET_CAPA:  if (tick_expired) state <= ARM;
        ARM: begin
          if (tick_expired) begin
            state <= EDGE;
            din   <= 1'b0;
          end
        end
        EDGE: begin
          // The cell must have inverted the falling input by the end of the interval
          if (tick_expired) begin
            if (dout != 1'b1) begin
              state    <= ERROR;
              din      <= 1'b1;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_MISMATCH;
            end else begin
              state    <= MEASURE;
              meas_req <= 1'b1;
            end
          end
        end
        MEASURE: begin
          if (meas_ack) begin
            state    <= RESTORE;
            meas_req <= 1'b0;
            din      <= 1'b1;
          end else if (wd_expired) begin
            state    <= ERROR;
            meas_req <= 1'b0;
            din      <= 1'b1;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end
        RESTORE: begin
          if (tick_expired) begin
            if (capa_idx != CAPA_LAST) begin
              capa_idx <= capa_idx + CW'(1);
              state    <= SET_CAPA;
            end else if (slope_idx != SLOPE_LAST) begin
              row_end   <= 1'b1;
              capa_idx  <= '0;
              slope_idx <= slope_idx + SW'(1);
              state     <= SET_SLOPE;
            end else begin
              row_end <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        ERROR: state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_sweep_sequencer.sv
// tb/tb_char_sweep_sequencer.sv - randomized self-checking bench for char_sweep_sequencer
module tb_char_sweep_sequencer;

  localparam int NS = 2;
  localparam int NC = 3;
  localparam int TK = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       meas_ack = 1'b0;
  logic       stuck = 1'b0;
  logic       dout;
  logic       din;
  logic [0:0] slope_idx;
  logic [1:0] capa_idx;
  logic       meas_req;
  logic       row_end;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  // Behavioural cell: an inverter, optionally stuck low
  assign dout = stuck ? 1'b0 : ~din;

  char_sweep_sequencer #(
    .NBSLOPES       (NS),
    .NBCAPA         (NC),
    .TICK_CYCLES    (TK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dout      (dout),
    .meas_ack  (meas_ack),
    .din       (din),
    .slope_idx (slope_idx),
    .capa_idx  (capa_idx),
    .meas_req  (meas_req),
    .row_end   (row_end),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // 0: ack tied high, 1: ack after delay_tab[point] cycles of request, 2: ack held low
  int ack_mode = 0;
  int delay_tab [NS*NC];
  int ack_cnt = 0;

  int busy_rise, done_rise, err_rise, row_ends, din_falls, req_len, unstable;
  int req_s, req_c;
  int hs_s[$];
  int hs_c[$];
  int hs_len[$];
  logic prev_busy = 1'b0, prev_done = 1'b0, prev_req = 1'b0, prev_din = 1'b1, prev_err = 1'b0;

  // Ack driver first, then the monitor sees the ack the DUT will sample next edge
  always @(negedge clk) begin
    if (ack_mode == 0) begin
      meas_ack = 1'b1;
      ack_cnt  = 0;
    end else if (ack_mode == 2) begin
      meas_ack = 1'b0;
      ack_cnt  = 0;
    end else if (meas_req) begin
      meas_ack = (ack_cnt >= delay_tab[int'(slope_idx)*NC + int'(capa_idx)]);
      ack_cnt++;
    end else begin
      meas_ack = 1'b0;
      ack_cnt  = 0;
    end

    if (busy && !prev_busy) busy_rise = cyc;
    if (done && !prev_done) done_rise = cyc;
    if (error && !prev_err) err_rise = cyc;
    if (row_end) row_ends++;
    if (!din && prev_din) din_falls++;
    if (meas_req) begin
      if (!prev_req) begin
        req_len = 0;
        req_s   = int'(slope_idx);
        req_c   = int'(capa_idx);
      end else if (int'(slope_idx) != req_s || int'(capa_idx) != req_c) begin
        unstable++;
      end
      req_len++;
      if (meas_ack) begin
        hs_s.push_back(req_s);
        hs_c.push_back(req_c);
        hs_len.push_back(req_len);
      end
    end
    prev_busy = busy;
    prev_done = done;
    prev_req  = meas_req;
    prev_din  = din;
    prev_err  = error;
  end

  task automatic clear_mon();
    busy_rise = -1; done_rise = -1; err_rise = -1;
    row_ends = 0; din_falls = 0; req_len = 0; unstable = 0;
    hs_s.delete(); hs_c.delete(); hs_len.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget, input int mid_at);
    int i;
    for (i = 0; i < budget && !(done || error); i++) begin
      @(negedge clk);
      if (i == mid_at) start = 1'b1;
      if (i == mid_at + 1) start = 1'b0;
    end
    start = 1'b0;
    #1;
    if (!(done || error)) check_eq({tag, "_bound"}, 32'(0), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_din"}, 32'(din), 32'(1));
    check_eq({tag, "_slope"}, 32'(slope_idx), 32'(0));
    check_eq({tag, "_capa"}, 32'(capa_idx), 32'(0));
    check_eq({tag, "_req"}, 32'(meas_req), 32'(0));
    check_eq({tag, "_row_end"}, 32'(row_end), 32'(0));
    check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    check_eq({tag, "_done"}, 32'(done), 32'(0));
    check_eq({tag, "_error"}, 32'(error), 32'(0));
    check_eq({tag, "_err_code"}, 32'(err_code), 32'(0));
  endtask

  // Model: nested slope/capa loops; each point is four quiet ticks plus its measure length
  task automatic run_sweep(input string tag, input int mode, input int mid_at);
    int exp_len [NS*NC];
    int exp_total;
    clear_mon();
    ack_mode  = mode;
    exp_total = NS * TK;
    for (int p = 0; p < NS*NC; p++) begin
      exp_len[p] = (mode == 0) ? 1 : delay_tab[p] + 1;
      exp_total += 4*TK + exp_len[p];
    end
    pulse_start();
    check_eq({tag, "_start_slope"}, 32'(slope_idx), 32'(0));
    check_eq({tag, "_start_capa"}, 32'(capa_idx), 32'(0));
    check_eq({tag, "_start_busy"}, 32'(busy), 32'(1));
    check_eq({tag, "_start_done"}, 32'(done), 32'(0));
    wait_end(tag, 3000, mid_at);
    check_eq({tag, "_handshakes"}, 32'(hs_s.size()), 32'(NS*NC));
    for (int p = 0; p < NS*NC && p < hs_s.size(); p++) begin
      check_eq($sformatf("%s_pt%0d_slope", tag, p), 32'(hs_s[p]), 32'(p / NC));
      check_eq($sformatf("%s_pt%0d_capa", tag, p), 32'(hs_c[p]), 32'(p % NC));
      check_eq($sformatf("%s_pt%0d_req_len", tag, p), 32'(hs_len[p]), 32'(exp_len[p]));
    end
    check_eq({tag, "_row_ends"}, 32'(row_ends), 32'(NS));
    check_eq({tag, "_idx_stable"}, 32'(unstable), 32'(0));
    check_eq({tag, "_done_latency"}, 32'(done_rise - busy_rise), 32'(exp_total));
    check_eq({tag, "_final_slope"}, 32'(slope_idx), 32'(NS-1));
    check_eq({tag, "_final_capa"}, 32'(capa_idx), 32'(NC-1));
    check_eq({tag, "_final_busy"}, 32'(busy), 32'(0));
    check_eq({tag, "_final_done"}, 32'(done), 32'(1));
    check_eq({tag, "_final_error"}, 32'(error), 32'(0));
  endtask

  initial begin
    int i;
    for (int p = 0; p < NS*NC; p++) delay_tab[p] = 0;
    clear_mon();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Ack tied high, start pulsed mid-sweep must be ignored
    run_sweep("tied", 0, 30);

    // Restart from DONE, point (0,1) acknowledged 5 cycles late
    for (int p = 0; p < NS*NC; p++) delay_tab[p] = $urandom_range(0, 4);
    delay_tab[1] = 5;
    run_sweep("delay01", 1, -10);

    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NS*NC; p++) delay_tab[p] = $urandom_range(0, 7);
      run_sweep($sformatf("rand%0d", r), 1, -10);
    end

    // Acknowledge withheld
    apply_reset();
    clear_mon();
    ack_mode = 2;
    pulse_start();
`ifdef CHAR_SWEEP_TIMEOUT_EN
    wait_end("timeout", 500, -10);
    check_eq("timeout_error", 32'(error), 32'(1));
    check_eq("timeout_code", 32'(err_code), 32'(2));
    check_eq("timeout_req_len", 32'(req_len), 32'(TO));
    check_eq("timeout_latency", 32'(err_rise - busy_rise), 32'(4*TK + TO));
    check_eq("timeout_req_low", 32'(meas_req), 32'(0));
    check_eq("timeout_din", 32'(din), 32'(1));
    check_eq("timeout_busy", 32'(busy), 32'(0));
`else
    for (i = 0; i < 200 && !meas_req; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    check_eq("hold_req", 32'(meas_req), 32'(1));
    check_eq("hold_error", 32'(error), 32'(0));
    check_eq("hold_busy", 32'(busy), 32'(1));
    for (int p = 0; p < NS*NC; p++) delay_tab[p] = 0;
    ack_mode = 1;
    wait_end("hold", 3000, -10);
    check_eq("hold_done", 32'(done), 32'(1));
    check_eq("hold_handshakes", 32'(hs_s.size()), 32'(NS*NC));
`endif

    // Asynchronous reset during the second EDGE
    apply_reset();
    clear_mon();
    ack_mode = 0;
    pulse_start();
    for (i = 0; i < 500 && din_falls < 2; i++) @(negedge clk);
    #1;
    check_eq("midreset_reach_edge2", 32'(din_falls), 32'(2));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (4) @(negedge clk);
    #1;
    check_eq("midreset_handshakes", 32'(hs_s.size()), 32'(1));
    check_eq("midreset_req_held_low", 32'(meas_req), 32'(0));
    rst_n = 1'b1;

    // Stuck cell output
    clear_mon();
    stuck = 1'b1;
    pulse_start();
    wait_end("stuck", 500, -10);
    check_eq("stuck_error", 32'(error), 32'(1));
    check_eq("stuck_code", 32'(err_code), 32'(1));
    check_eq("stuck_latency", 32'(err_rise - busy_rise), 32'(4*TK));
    check_eq("stuck_din", 32'(din), 32'(1));
    check_eq("stuck_busy", 32'(busy), 32'(0));
    check_eq("stuck_req", 32'(meas_req), 32'(0));
    check_eq("stuck_handshakes", 32'(hs_s.size()), 32'(0));
    pulse_start();
    repeat (6) @(negedge clk);
    check_eq("stuck_start_ignored_busy", 32'(busy), 32'(0));
    check_eq("stuck_start_ignored_error", 32'(error), 32'(1));
    check_eq("stuck_start_ignored_code", 32'(err_code), 32'(1));
    check_eq("stuck_start_ignored_din", 32'(din), 32'(1));
    stuck = 1'b0;
    apply_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_sweep_sequencer.md
# char_sweep_sequencer

Synthesizable stimulus sequencer that sits directly upstream of the cell-characterization breadboard. It walks the input-slope by load-capacitance grid, drives the cell's logic input `din` with a fall-then-restore event per grid point, and checks the cell output. At each point it hands a measurement request to the downstream capture logic and waits for its acknowledge.

## Interface
Parameters:
- `NBSLOPES`, 7: number of input-slope grid points.
- `NBCAPA`, 7: number of load-capacitor grid points.
- `TICK_CYCLES`, 10: clock cycles per quiet interval ("tick"); must be ≥2.
- `TIMEOUT_CYCLES`, 255: acknowledge watchdog limit; used only with `CHAR_SWEEP_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: sweep request, sampled in IDLE/DONE only.
- `dout` input 1: cell output, compared against `!din`.
- `meas_ack` input 1: capture stage has taken the measurement.
- `din` output 1: cell input stimulus.
- `slope_idx` output `$clog2(NBSLOPES)`: current slope index.
- `capa_idx` output `$clog2(NBCAPA)`: current capacitor index.
- `meas_req` output 1: measurement request; indices are stable while it is high.
- `row_end` output 1: one-cycle pulse after the last capacitor point of a slope row.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep completed; level signal.
- `error` output 1: sticky failure flag.
- `err_code` output 2: 0 none, 1 output mismatch, 2 acknowledge timeout.

## Operation
- States: IDLE, SET_SLOPE, SET_CAPA, ARM, EDGE, MEASURE, RESTORE, DONE, ERROR.
- IDLE or DONE, with `start`=1 → SET_SLOPE. On this transition `slope_idx`=0, `capa_idx`=0, `done`=0, `busy`=1.
- SET_SLOPE, SET_CAPA, ARM, EDGE and RESTORE each last exactly `TICK_CYCLES` cycles, counted by one down-counter reloaded on state entry.
- SET_SLOPE → SET_CAPA.
- SET_CAPA → ARM.
- ARM → EDGE. `din` is driven 0 on the EDGE entry edge.
- EDGE, last cycle: sample `dout`.
  - `dout` != 1 → ERROR with `err_code`=1.
  - Otherwise → MEASURE.
- MEASURE: `meas_req`=1.
  - In the cycle where `meas_req` && `meas_ack` → RESTORE. `meas_req` is 0 from the next cycle.
  - `meas_ack` outside MEASURE is ignored.
- RESTORE: `din` is driven 1 on entry. On exit:
  - `capa_idx` < `NBCAPA`-1 → increment `capa_idx`, go to SET_CAPA.
  - Else, `slope_idx` < `NBSLOPES`-1 → pulse `row_end`, `capa_idx`=0, increment `slope_idx`, go to SET_SLOPE.
  - Else → pulse `row_end`, go to DONE with `busy`=0, `done`=1.
- Index counters never wrap past their limit. `slope_idx` and `capa_idx` keep their final values in DONE.
- ERROR: `din`=1, `meas_req`=0, `busy`=0, `error`=1. Exit only by reset; `start` is ignored.
- `start` while busy: ignored.

## Timing
- Reset values, applied asynchronously: `din`=1, indices 0, `meas_req`=0, `row_end`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0. State is IDLE.
- `rst_n` asserted mid-sweep aborts immediately to reset values. No handshake completes.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `busy` rises 1 cycle after `start` is sampled.
- Cycles per grid point: 4·`TICK_CYCLES` + MEASURE length, where MEASURE length ≥1.
- Per slope row: `TICK_CYCLES` + `NBCAPA` × per-point cycles.
- `done` rises in the cycle after the last RESTORE ends.

## Configuration
- `CHAR_SWEEP_TIMEOUT_EN` defined:
  - An 8+ bit counter runs in MEASURE.
  - After `TIMEOUT_CYCLES` cycles with no `meas_ack`, the block enters ERROR with `err_code`=2.
- `CHAR_SWEEP_TIMEOUT_EN` undefined:
  - The counter is absent and MEASURE waits indefinitely.
  - `err_code`=2 is never produced.

## Structure
- Package `char_sweep_pkg`: state enum `sweep_state_e`, error enum `sweep_err_e` (ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT), and default grid sizes.
- Sub-module `tick_timer`: loadable down-counter with an `expired` flag. It is reused for the tick counting and for the watchdog.

## Test plan
All scenarios use `NBSLOPES`=2, `NBCAPA`=3, `TICK_CYCLES`=4.
- Full sweep, `meas_ack` tied to 1, `dout` = model of `!din`:
  - exactly 6 handshakes, index pairs (0,0)(0,1)(0,2)(1,0)(1,1)(1,2);
  - 2 `row_end` pulses;
  - `done` rises 110 cycles after `busy` rises.
- Stuck `dout`=0 → `error`=1 and `err_code`=1 at the end of the first EDGE; `din`=1, `start` ignored afterwards.
- Delay `meas_ack` by 5 cycles at point (0,1) → `meas_req` held high 6 cycles, indices stable, sweep completes.
- Assert `rst_n`=0 during the second EDGE → all outputs immediately at reset values.
- `start` pulsed during the sweep → no effect. `start` pulsed in DONE → a new sweep from (0,0).
- With `CHAR_SWEEP_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, hold `meas_ack`=0 → ERROR with `err_code`=2 after 16 cycles in MEASURE.
